// File: rtl/submix_seq.sv
// rtl/submix_seq.sv - sequential SubBytes + MixColumns column datapath with N shared S-boxes
module submix_seq #(
    parameter int SBOX_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    generate
        if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 || SBOX_PER_CYCLE == 4)) begin : g_bad_param
            $error("submix_seq: SBOX_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         N      = SBOX_PER_CYCLE;
    localparam logic [1:0] K_LAST = 2'(4 / N - 1);

    typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_cnt_q, k_cnt_d;
    logic [31:0] col_q, col_d;
    logic [31:0] sub_q, sub_d;
    logic        last_q, last_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] merged;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the forward affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Only the N lanes selected by k_cnt go through the S-boxes this cycle.
    always_comb begin
        int lane;
        lane   = 0;
        merged = sub_q;
        for (int j = 0; j < N; j++) begin
            lane = int'(k_cnt_q) * N + j;
            merged[31 - 8 * lane -: 8] = sbox(col_q[31 - 8 * lane -: 8]);
        end
    end

    assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        col_d       = col_q;
        sub_d       = sub_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    col_d   = in_data;
                    last_d  = in_last;
                    k_cnt_d = 2'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                sub_d = merged;
                if (k_cnt_q == K_LAST) begin
                    out_data_d  = last_q ? merged : mix(merged);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    k_cnt_d = k_cnt_q + 2'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        col_d   = in_data;
                        last_d  = in_last;
                        k_cnt_d = 2'd0;
                        state_d = SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_cnt_q     <= 2'd0;
            col_q       <= 32'h0;
            sub_q       <= 32'h0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            col_q       <= col_d;
            sub_q       <= sub_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_submix_seq.sv
// tb/tb_submix_seq.sv - directed bench for submix_seq at N=1, 2 and 4
module tb_submix_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv[3];
    logic        ir[3];
    logic        il[3];
    logic        ov[3];
    logic        ordy[3];
    logic [31:0] id[3];
    logic [31:0] od[3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    submix_seq #(.SBOX_PER_CYCLE(1)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
    submix_seq #(.SBOX_PER_CYCLE(2)) u_n2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
    submix_seq #(.SBOX_PER_CYCLE(4)) u_n4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b0; id[i] = 32'h0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(ir[i]), 32'd1);
            check("rst_out_valid", 32'(ov[i]), 32'd0);
            check("rst_out_data", od[i], 32'h0);
        end
        rst = 1'b0;
        tick();

        // N=1 single column, MixColumns applied
        iv[0] = 1'b1; id[0] = 32'h9F825068; il[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        iv[0] = 1'b0; id[0] = 32'hFFFFFFFF;
        for (int c = 1; c < 4; c++) begin
            check("n1_sub_in_ready", 32'(ir[0]), 32'd0);
            check("n1_sub_out_valid", 32'(ov[0]), 32'd0);
            tick();
        end
        check("n1_sub_in_ready", 32'(ir[0]), 32'd0);
        check("n1_sub_out_valid", 32'(ov[0]), 32'd0);
        tick();
        check("n1_out_valid", 32'(ov[0]), 32'd1);
        check("n1_out_data", od[0], 32'h8E4DA1BC);
        tick();
        check("n1_valid_one_cycle", 32'(ov[0]), 32'd0);
        check("n1_idle_in_ready", 32'(ir[0]), 32'd1);

        // N=4 last round, MixColumns bypassed
        iv[2] = 1'b1; id[2] = 32'h9F825068; il[2] = 1'b1; ordy[2] = 1'b1;
        tick();
        iv[2] = 1'b0; il[2] = 1'b0;
        check("n4_sub_out_valid", 32'(ov[2]), 32'd0);
        tick();
        check("n4_out_valid", 32'(ov[2]), 32'd1);
        check("n4_out_data", od[2], 32'hDB135345);
        tick();
        check("n4_back_idle", 32'(ov[2]), 32'd0);

        // N=2 zero column, stalled downstream with a competing input
        iv[1] = 1'b1; id[1] = 32'h00000000; il[1] = 1'b0; ordy[1] = 1'b0;
        tick();
        iv[1] = 1'b1; id[1] = 32'h12345678;
        check("n2_sub_out_valid", 32'(ov[1]), 32'd0);
        tick();
        check("n2_sub_out_valid", 32'(ov[1]), 32'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("n2_stall_out_valid", 32'(ov[1]), 32'd1);
            check("n2_stall_out_data", od[1], 32'h63636363);
            check("n2_stall_in_ready", 32'(ir[1]), 32'd0);
            tick();
        end
        iv[1] = 1'b0; ordy[1] = 1'b1;
        #1;
        check("n2_release_in_ready", 32'(ir[1]), 32'd1);
        tick();
        check("n2_idle_out_valid", 32'(ov[1]), 32'd0);
        check("n2_idle_in_ready", 32'(ir[1]), 32'd1);

        // N=1 back-to-back with in_last toggled after accept
        iv[0] = 1'b1; id[0] = 32'h9F825068; il[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        id[0] = 32'h00000000; il[0] = 1'b1;
        for (int c = 1; c < 4; c++) begin
            check("b2b_first_wait", 32'(ov[0]), 32'd0);
            tick();
        end
        il[0] = 1'b0;
        check("b2b_first_wait", 32'(ov[0]), 32'd0);
        tick();
        check("b2b_first_valid", 32'(ov[0]), 32'd1);
        check("b2b_first_data", od[0], 32'h8E4DA1BC);
        check("b2b_hold_in_ready", 32'(ir[0]), 32'd1);
        tick();
        check("b2b_accept_drop", 32'(ov[0]), 32'd0);
        check("b2b_accept_in_ready", 32'(ir[0]), 32'd0);
        iv[0] = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            check("b2b_second_wait", 32'(ov[0]), 32'd0);
        end
        tick();
        check("b2b_second_valid", 32'(ov[0]), 32'd1);
        check("b2b_second_data", od[0], 32'h63636363);
        tick();
        check("b2b_done", 32'(ov[0]), 32'd0);

        // N=1 reset mid-SUB at k_cnt=2
        iv[0] = 1'b1; id[0] = 32'hA5A5A5A5; il[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(ov[0]), 32'd0);
        check("rst_mid_out_data", od[0], 32'h0);
        check("rst_mid_in_ready", 32'(ir[0]), 32'd1);
        #3;
        rst = 1'b0;
        tick();
        iv[0] = 1'b1; id[0] = 32'h9F825068; il[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        for (int c = 1; c < 4; c++) begin
            check("rst_after_wait", 32'(ov[0]), 32'd0);
            tick();
        end
        check("rst_after_wait", 32'(ov[0]), 32'd0);
        tick();
        check("rst_after_valid", 32'(ov[0]), 32'd1);
        check("rst_after_data", od[0], 32'h8E4DA1BC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
